// File: rtl/serial_adder_pkg.sv
// Shared encodings between the serial-adder control FSM and its datapath.
package serial_adder_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_WAIT = 2'b00,
        ST_WORK = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/serial_add_datapath_if.sv
// Control/operand/result bundle between the serial-adder FSM (master) and datapath (slave).
interface serial_add_datapath_if #(
    parameter int unsigned WIDTH = 8
);
    import serial_adder_pkg::*;

    logic [STATE_W-1:0] state;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               counterflag;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic               ovf;
    logic               sum_valid;

    modport master (
        output state, a, b,
        input  counterflag, sum, cout, ovf, sum_valid
    );

    modport slave (
        input  state, a, b,
        output counterflag, sum, cout, ovf, sum_valid
    );

endinterface

// File: rtl/serial_add_datapath_fa.sv
// Single-bit full adder used as the serial bit slice.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_add_datapath.sv
// Bit-serial adder datapath: loads operands in WAIT, adds LSB-first in WORK, holds in DONE.
module serial_add_datapath
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_add_datapath_if.slave  bus
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           st;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             fa_s, fa_cout;
    logic             last_bit;

    assign st       = state_e'(bus.state);
    assign last_bit = (st == ST_WORK) && (cnt_q == LAST_CNT);

    full_adder_bit u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (st)
            ST_WAIT: begin
                a_d     = bus.a;
                b_d     = bus.b;
                carry_d = 1'b0;
                cnt_d   = '0;
            end
            ST_WORK: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + 1'b1;
                // Flags are captured only on the MSB slice; carry_q is the MSB carry-in.
                if (last_bit) begin
                    cout_d = fa_cout;
                    ovf_d  = carry_q ^ fa_cout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.counterflag = last_bit;
    assign bus.sum_valid   = (st == ST_DONE);
    assign bus.sum         = sum_q;
    assign bus.cout        = cout_q;
    assign bus.ovf         = ovf_q;

endmodule

// File: tb/tb_serial_add_datapath.sv
// Directed plus randomized bench for serial_add_datapath against an arithmetic reference.
module tb_serial_add_datapath;
    import serial_adder_pkg::*;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [W-1:0] prev_sum;
    logic         prev_cout;
    logic         prev_ovf;

    serial_add_datapath_if #(.WIDTH(W)) bus ();

    serial_add_datapath #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer addition, overflow from operand/result signs.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] s, output logic c, output logic o);
        logic [W:0] t;
        t = {1'b0, a} + {1'b0, b};
        s = t[W-1:0];
        c = t[W];
        o = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    // Shift register contents after k serial steps: new low bits enter from the top.
    function automatic logic [W-1:0] partial(input logic [W-1:0] ns, input logic [W-1:0] ps,
                                             input int unsigned k);
        logic [2*W-1:0] cat;
        cat = {ns, ps} >> k;
        return cat[W-1:0];
    endfunction

    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble,
                           input int pause_at, input int unsigned hold_cycles);
        logic [W-1:0] es;
        logic         ec, eo;
        model(a, b, es, ec, eo);
        bus.state = ST_WAIT;
        bus.a = a;
        bus.b = b;
        #1;
        chk("wait_sum_held", 32'(bus.sum), 32'(prev_sum));
        chk("wait_cout_held", 32'(bus.cout), 32'(prev_cout));
        chk("wait_ovf_held", 32'(bus.ovf), 32'(prev_ovf));
        chk("wait_valid", 32'(bus.sum_valid), 32'd0);
        chk("wait_cflag", 32'(bus.counterflag), 32'd0);
        tick();
        for (int i = 0; i < int'(W); i++) begin
            if (i == pause_at) begin
                bus.state = 2'b11;
                for (int p = 0; p < 3; p++) begin
                    #1;
                    chk("ill_cflag", 32'(bus.counterflag), 32'd0);
                    chk("ill_valid", 32'(bus.sum_valid), 32'd0);
                    chk("ill_sum", 32'(bus.sum), 32'(partial(es, prev_sum, i)));
                    tick();
                end
            end
            bus.state = ST_WORK;
            if (scramble) begin
                bus.a = W'($urandom);
                bus.b = W'($urandom);
            end
            #1;
            chk("work_cflag", 32'(bus.counterflag), (i == int'(W) - 1) ? 32'd1 : 32'd0);
            chk("work_valid", 32'(bus.sum_valid), 32'd0);
            tick();
        end
        bus.state = ST_DONE;
        prev_sum  = es;
        prev_cout = ec;
        prev_ovf  = eo;
        for (int unsigned h = 0; h < hold_cycles; h++) begin
            #1;
            chk("done_sum", 32'(bus.sum), 32'(es));
            chk("done_cout", 32'(bus.cout), 32'(ec));
            chk("done_ovf", 32'(bus.ovf), 32'(eo));
            chk("done_valid", 32'(bus.sum_valid), 32'd1);
            chk("done_cflag", 32'(bus.counterflag), 32'd0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.state = ST_WAIT;
        bus.a = '0;
        bus.b = '0;
        prev_sum = '0;
        prev_cout = 1'b0;
        prev_ovf = 1'b0;
        tick();
        tick();
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_valid", 32'(bus.sum_valid), 32'd0);
        chk("rst_cflag", 32'(bus.counterflag), 32'd0);
        rst = 1'b1;

        run_add(8'h5A, 8'h3C, 1'b0, -1, 1);
        run_add(8'hFF, 8'h01, 1'b0, -1, 1);
        run_add(8'h80, 8'h80, 1'b0, -1, 1);
        run_add(8'h6B, 8'h2D, 1'b1, -1, 5);
        run_add(8'hA7, 8'h19, 1'b0, 3, 1);
        run_add(8'h33, 8'h44, 1'b0, -1, 2);

        // Abort mid-WORK: reset on the 4th WORK cycle
        bus.state = ST_WAIT;
        bus.a = 8'h77;
        bus.b = 8'h11;
        tick();
        bus.state = ST_WORK;
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.state = ST_DONE;
        #1;
        chk("abort_sum", 32'(bus.sum), 32'd0);
        chk("abort_cout", 32'(bus.cout), 32'd0);
        chk("abort_ovf", 32'(bus.ovf), 32'd0);
        tick();
        // Counter must restart from zero: flag only on the W-th WORK cycle
        for (int i = 0; i < int'(W); i++) begin
            bus.state = ST_WORK;
            #1;
            chk("abort_cflag", 32'(bus.counterflag), (i == int'(W) - 1) ? 32'd1 : 32'd0);
            tick();
        end
        bus.state = ST_DONE;
        #1;
        chk("abort_zero_sum", 32'(bus.sum), 32'd0);
        prev_sum = '0;
        prev_cout = 1'b0;
        prev_ovf = 1'b0;
        run_add(8'h12, 8'h34, 1'b0, -1, 1);

        for (int n = 0; n < 20; n++) begin
            run_add(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1,
                    $urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
